// File: rtl/bus_arbiter_2to1.sv
// Two-requester round-robin bus arbiter that drives the common select of the DATA_W MUX_2to1_1B slices.
// Define ARB_PREEMPT_EN to enable hold-limit preemption after MAX_HOLD contended cycles.
module bus_arbiter_2to1 #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              sel,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_valid,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  if (MAX_HOLD < 2 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 2..15");
  end

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   gnt_a_q, gnt_a_d;
  logic   gnt_b_q, gnt_b_d;
  logic   sel_q, sel_d;
`ifdef ARB_PREEMPT_EN
  logic [3:0] hold_cnt_q, hold_cnt_d;
`endif

  // last_q: 0 = A was granted last, 1 = B was granted last
  always_comb begin
    state_d = state_q;
`ifdef ARB_PREEMPT_EN
    hold_cnt_d = '0;
`endif
    case (state_q)
      IDLE: begin
        if (req_a && req_b) state_d = last_q ? OWN_A : OWN_B;
        else if (req_a)     state_d = OWN_A;
        else if (req_b)     state_d = OWN_B;
      end
      OWN_A: begin
        if (!req_a) begin
          state_d = req_b ? OWN_B : IDLE;
        end else if (req_b) begin
`ifdef ARB_PREEMPT_EN
          if (hold_cnt_q == 4'(MAX_HOLD - 1)) state_d = OWN_B;
          else                                hold_cnt_d = hold_cnt_q + 4'd1;
`endif
        end
      end
      OWN_B: begin
        if (!req_b) begin
          state_d = req_a ? OWN_A : IDLE;
        end else if (req_a) begin
`ifdef ARB_PREEMPT_EN
          if (hold_cnt_q == 4'(MAX_HOLD - 1)) state_d = OWN_A;
          else                                hold_cnt_d = hold_cnt_q + 4'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    last_d  = last_q;
    sel_d   = sel_q;
    gnt_a_d = (state_d == OWN_A);
    gnt_b_d = (state_d == OWN_B);
    // Select and priority only move on ownership; IDLE keeps sel so the bus does not glitch
    if (state_d == OWN_A) begin
      last_d = 1'b0;
      sel_d  = 1'b0;
    end else if (state_d == OWN_B) begin
      last_d = 1'b1;
      sel_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      sel_q      <= 1'b0;
`ifdef ARB_PREEMPT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      sel_q      <= sel_d;
`ifdef ARB_PREEMPT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign sel       = sel_q;
  assign busy      = gnt_a_q | gnt_b_q;
  assign bus_data  = sel_q ? data_b : data_a;
  assign bus_valid = (gnt_a_q & req_a) | (gnt_b_q & req_b);

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Randomized self-checking bench for bus_arbiter_2to1 against an ownership-level reference model.
// Honours ARB_PREEMPT_EN the same way the design does.
module tb_bus_arbiter_2to1;

  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_a = 1'b0;
  logic              req_b = 1'b0;
  logic [DATA_W-1:0] data_a = '0;
  logic [DATA_W-1:0] data_b = '0;
  logic              gnt_a, gnt_b, sel, bus_valid, busy;
  logic [DATA_W-1:0] bus_data;

  bus_arbiter_2to1 #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .sel(sel), .bus_data(bus_data), .bus_valid(bus_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: owner 0 = nobody, 1 = A, 2 = B; run counts contended cycles of the current owner
  int   owner = 0;
  int   last_side = 2;
  int   run = 0;
  logic exp_sel = 1'b0;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_step();
    int nxt;
    bit mine, other;
    if (rst) begin
      owner = 0; last_side = 2; run = 0; exp_sel = 1'b0;
      return;
    end
    nxt = owner;
    if (owner == 0) begin
      if (req_a && req_b) nxt = (last_side == 2) ? 1 : 2;
      else if (req_a)     nxt = 1;
      else if (req_b)     nxt = 2;
    end else begin
      mine  = (owner == 1) ? req_a : req_b;
      other = (owner == 1) ? req_b : req_a;
      if (!mine) begin
        nxt = other ? 3 - owner : 0;
      end else if (other) begin
        run++;
`ifdef ARB_PREEMPT_EN
        if (run == MAX_HOLD) nxt = 3 - owner;
`endif
      end else begin
        run = 0;
      end
    end
    if (nxt != owner) run = 0;
    if (nxt != 0) begin
      last_side = nxt;
      exp_sel   = (nxt == 2);
    end
    owner = nxt;
  endtask

  task automatic check_output();
    logic exp_valid;
    exp_valid = ((owner == 1) && req_a) || ((owner == 2) && req_b);
    check_val("gnt_a",     gnt_a,     (owner == 1));
    check_val("gnt_b",     gnt_b,     (owner == 2));
    check_val("sel",       sel,       exp_sel);
    check_val("busy",      busy,      (owner != 0));
    check_val("bus_valid", bus_valid, exp_valid);
    check_val("bus_data",  bus_data,  exp_sel ? data_b : data_a);
  endtask

  // Inputs change on the falling edge, outputs are compared on the next falling edge
  task automatic apply_stimulus(input logic r, input logic ra, input logic rb,
                                input logic [DATA_W-1:0] da, input logic [DATA_W-1:0] db);
    rst = r; req_a = ra; req_b = rb; data_a = da; data_b = db;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_output();
  endtask

  initial begin
    logic ra, rb, rr;
    @(negedge clk);

    apply_stimulus(1, 0, 0, 8'h00, 8'h00);
    apply_stimulus(1, 0, 0, 8'h00, 8'h00);
    check_val("reset_gnt_a", gnt_a, 0);
    check_val("reset_gnt_b", gnt_b, 0);
    check_val("reset_sel", sel, 0);
    check_val("reset_valid", bus_valid, 0);
    check_val("reset_busy", busy, 0);

    apply_stimulus(0, 1, 0, 8'h3C, 8'h00);
    check_val("single_gnt_a", gnt_a, 1);
    check_val("single_data", bus_data, 8'h3C);
    check_val("single_valid", bus_valid, 1);
    apply_stimulus(0, 1, 0, 8'h3C, 8'h00);
    apply_stimulus(0, 1, 0, 8'h3C, 8'h00);
    apply_stimulus(0, 0, 0, 8'h3C, 8'h00);
    check_val("release_gnt_a", gnt_a, 0);
    check_val("release_busy", busy, 0);

    apply_stimulus(1, 0, 0, 8'h11, 8'hA5);
    apply_stimulus(0, 1, 1, 8'h11, 8'hA5);
    check_val("tie_gnt_a", gnt_a, 1);
    check_val("tie_gnt_b", gnt_b, 0);
    apply_stimulus(0, 0, 1, 8'h11, 8'hA5);
    check_val("handover_gnt_a", gnt_a, 0);
    check_val("handover_gnt_b", gnt_b, 1);
    check_val("handover_sel", sel, 1);
    check_val("handover_data", bus_data, 8'hA5);

    apply_stimulus(1, 0, 0, 8'h22, 8'h33);
    for (int k = 1; k <= 20; k++) begin
      apply_stimulus(0, 1, 1, 8'h22, 8'h33);
`ifdef ARB_PREEMPT_EN
      if (k == 4) check_val("preempt_c4_gnt_a", gnt_a, 1);
      if (k == 5) check_val("preempt_c5_gnt_b", gnt_b, 1);
      if (k == 9) check_val("preempt_c9_gnt_a", gnt_a, 1);
`else
      if (k == 20) check_val("hold_c20_gnt_a", gnt_a, 1);
`endif
    end
    apply_stimulus(0, 0, 1, 8'h22, 8'h33);
    check_val("drop_gnt_b", gnt_b, 1);

    apply_stimulus(1, 1, 1, 8'h44, 8'h55);
    check_val("midrst_gnt_b", gnt_b, 0);
    check_val("midrst_sel", sel, 0);
    apply_stimulus(0, 1, 1, 8'h44, 8'h55);
    check_val("after_rst_gnt_a", gnt_a, 1);

    ra = 0; rb = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) ra = ~ra;
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      rr = ($urandom_range(0, 39) == 0);
      apply_stimulus(rr, ra, rb, DATA_W'($urandom), DATA_W'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
